// File: rtl/led_fade_pwm.sv
// LED brightness fader: free-running PWM whose duty level ramps one LSB at a time toward a
// requested target, changing only at PWM period boundaries so each period is glitch-free.
module led_fade_pwm #(
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned FADE_STEP_PRDS = 4
) (
    input  logic                clk_100K,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] target_i,
    input  logic                target_valid_i,
    output logic                target_ready_o,
    output logic                led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                busy_o
);

    localparam int unsigned StepW = (FADE_STEP_PRDS > 1) ? $clog2(FADE_STEP_PRDS) : 1;

    // Counter tops out one short of the level maximum so level max means "always on".
    localparam logic [PWM_BITS-1:0] CntMax   = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [StepW-1:0]    StepLast = StepW'(FADE_STEP_PRDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StFade
    } state_e;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] target_q, target_d;
    logic [StepW-1:0]    step_q, step_d;
    logic                led_q, led_d;

    logic                boundary;
    logic                accept;
    logic                step_done;
    logic [PWM_BITS-1:0] level_step;

    assign boundary   = (pwm_cnt_q == CntMax);
    assign accept     = target_valid_i && (state_q == StIdle);
    assign step_done  = (state_q == StFade) && boundary && (step_q == StepLast);
    assign level_step = (target_q > level_q) ? level_q + 1'b1 : level_q - 1'b1;

    // State register
    always_ff @(posedge clk_100K or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (target_i != level_q)) begin
                    state_d = StFade;
                end
            end
            StFade: begin
                if (step_done && (level_step == target_q)) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        target_ready_o = 1'b0;
        busy_o         = 1'b0;
        unique case (state_q)
            StIdle: target_ready_o = 1'b1;
            StFade: busy_o         = 1'b1;
        endcase
    end

    // Datapath next-state
    always_comb begin
        pwm_cnt_d = boundary ? '0 : pwm_cnt_q + 1'b1;
        led_d     = (pwm_cnt_q < level_q);
        level_d   = step_done ? level_step : level_q;
        target_d  = target_q;
        step_d    = step_q;
        if (accept) begin
            target_d = target_i;
            step_d   = '0;
        end else if ((state_q == StFade) && boundary) begin
            step_d = (step_q == StepLast) ? '0 : step_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100K or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            level_q   <= '0;
            target_q  <= '0;
            step_q    <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            level_q   <= level_d;
            target_q  <= target_d;
            step_q    <= step_d;
            led_q     <= led_d;
        end
    end

    assign led_o   = led_q;
    assign level_o = level_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: expected level sequences are queued at acceptance and a
// monitor checks each level_o change (value, boundary spacing, ready/busy) as it appears.
`timescale 1ns/1ps
module tb_led_fade_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a_target, a_level;
    logic       a_valid, a_ready, a_led, a_busy;
    logic [3:0] b_target, b_level;
    logic       b_valid, b_ready, b_led, b_busy;

    led_fade_pwm #(.PWM_BITS(8), .FADE_STEP_PRDS(2)) dut_a (
        .clk_100K      (clk),
        .rst           (rst),
        .target_i      (a_target),
        .target_valid_i(a_valid),
        .target_ready_o(a_ready),
        .led_o         (a_led),
        .level_o       (a_level),
        .busy_o        (a_busy)
    );

    led_fade_pwm #(.PWM_BITS(4), .FADE_STEP_PRDS(1)) dut_b (
        .clk_100K      (clk),
        .rst           (rst),
        .target_i      (b_target),
        .target_valid_i(b_valid),
        .target_ready_o(b_ready),
        .led_o         (b_led),
        .level_o       (b_level),
        .busy_o        (b_busy)
    );

    int tests = 0;
    int fails = 0;
    int a_q[$];
    int a_cur = 0;
    int b_goal = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Bench reference of period boundaries and of when an acceptance should happen.
    int unsigned a_mcnt;
    logic        a_bnd_edge, a_acc_edge;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mcnt     <= 0;
            a_bnd_edge <= 1'b0;
            a_acc_edge <= 1'b0;
        end else begin
            a_mcnt     <= (a_mcnt == 254) ? 0 : a_mcnt + 1;
            a_bnd_edge <= (a_mcnt == 254);
            a_acc_edge <= a_valid && (a_q.size() == 0);
        end
    end

    // Monitor for DUT A
    initial begin
        int prev;
        int bcnt;
        int exp;
        prev = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = a_level;
                bcnt = 0;
                continue;
            end
            if (a_acc_edge) bcnt = 0;
            else if (a_bnd_edge) bcnt++;
            if (a_level != prev) begin
                if (a_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_unexpected_level: got %0d, expected %0d", a_level, prev);
                end else begin
                    exp = a_q.pop_front();
                    check("a_level", a_level, exp);
                    check("a_step_gap", bcnt, 2);
                    check("a_ready_at_step", a_ready, a_q.size() == 0);
                    check("a_busy_at_step", a_busy, a_q.size() != 0);
                end
                bcnt = 0;
                prev = a_level;
            end
        end
    end

    // Monitor for DUT B: every change is one LSB toward the goal
    initial begin
        int prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = b_level;
                continue;
            end
            if (b_level != prev) begin
                check("b_step", b_level, (b_goal > prev) ? prev + 1 : prev - 1);
                prev = b_level;
            end
        end
    end

    task automatic a_accept(input int t);
        @(negedge clk);
        check("a_ready_before_accept", a_ready, 1);
        a_target = t[7:0];
        a_valid  = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("a_busy_after_accept", a_busy, t != a_cur);
        if (t > a_cur) for (int v = a_cur + 1; v <= t; v++) a_q.push_back(v);
        else for (int v = a_cur - 1; v >= t; v--) a_q.push_back(v);
        a_cur = t;
    endtask

    task automatic a_wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (a_q.size() == 0 && a_ready) break;
        end
        check("a_fade_done_in_budget", n < budget, 1);
        check("a_final_level", a_level, a_cur);
    endtask

    task automatic b_fade(input int t);
        int n;
        b_goal = t;
        @(negedge clk);
        b_target = t[3:0];
        b_valid  = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (b_level == t[3:0] && b_ready) break;
        end
        check("b_fade_done_in_budget", n < 600, 1);
        check("b_final_level", b_level, t);
        check("b_busy_after_fade", b_busy, 0);
    endtask

    initial begin
        int cnt;
        int n;
        int nb;
        rst      = 1'b1;
        a_valid  = 1'b0;
        a_target = '0;
        b_valid  = 1'b0;
        b_target = '0;
        repeat (3) @(negedge clk);
        check("rst_led", a_led, 0);
        check("rst_level", a_level, 0);
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        rst = 1'b0;

        // Full-scale fade on the small instance: up to max, then back down to zero
        b_fade(15);
        @(negedge clk);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            cnt += b_led;
        end
        check("b_max_led_high", cnt, 60);
        b_fade(0);
        @(negedge clk);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            cnt += b_led;
        end
        check("b_zero_led_high", cnt, 0);

        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            cnt += a_led;
        end
        check("a_idle_led_high", cnt, 0);

        // Target equal to current level is a no-op
        a_accept(0);
        cnt = 0;
        n   = 0;
        repeat (600) begin
            @(negedge clk);
            cnt += a_busy;
            n   += !a_ready;
        end
        check("a_noop_busy_cycles", cnt, 0);
        check("a_noop_not_ready_cycles", n, 0);

        a_accept(3);
        a_wait_idle(3000);
        @(negedge clk);
        cnt = 0;
        repeat (255) begin
            @(negedge clk);
            cnt += a_led;
        end
        check("a_duty_3", cnt, 3);

        // New target while fading must be ignored
        a_accept(10);
        repeat (300) @(negedge clk);
        check("a_ready_while_fading", a_ready, 0);
        a_target = 8'd50;
        a_valid  = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        a_wait_idle(5000);

        // Reset mid-fade
        a_accept(200);
        nb = 0;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (a_bnd_edge) nb++;
            if (nb == 5) break;
        end
        check("a_five_boundaries_seen", nb, 5);
        check("a_level_after_5_bnd", a_level, 12);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", a_led, 0);
        check("async_rst_level", a_level, 0);
        check("async_rst_ready", a_ready, 1);
        check("async_rst_busy", a_busy, 0);
        a_q.delete();
        a_cur = 0;
        @(negedge clk);
        @(negedge clk);
        a_target = 8'd1;
        a_valid  = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        check("a_busy_after_release_accept", a_busy, 1);
        a_q.push_back(1);
        a_cur = 1;
        n = 1;
        while (a_level != 8'd1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("a_first_step_clock_after_release", n, 510);
        check("a_ready_after_release_fade", a_ready, 1);
        repeat (5) @(negedge clk);
        check("a_queue_drained", a_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
